lbr_drain_engine: RTL and testbench
===================================

Name: lbr_drain_engine

Overview:
- Downstream consumer of the LBR unit's read port.
- On a start pulse it reads every branch record (source PC and target) out of the LBR and streams them as a valid/ready word stream to a monitor/checker. It can optionally clear the LBR afterwards.
- It owns the LBR's lbrReq/RW_address inputs and consumes its output_data, so software or a security checker can snapshot branch history without stalling the core.

Parameters:
- DATA_WIDTH, 16, width of LBR data words and stream data.
- ADDR_WIDTH, 16, width of RW_address driven to the LBR.
- LBR_DEPTH, 8, number of branch records; the engine reads 2*LBR_DEPTH words.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset); deassertion is synchronous to clock.
- start  in  1  one-cycle pulse that begins a drain; ignored while busy=1.
- clear_after  in  1  sampled with an accepted start; 1 = clear the LBR after the last word.
- lbrReq  out  2  LBR request: 2'b00 idle, 2'b10 read, 2'b11 clear.
- RW_address  out  ADDR_WIDTH  LBR word address; 0 whenever lbrReq=2'b00.
- lbr_data  in  DATA_WIDTH  LBR output_data; valid the cycle after a read request.
- out_valid  out  1  stream word valid.
- out_ready  in  1  stream consumer ready.
- out_data  out  DATA_WIDTH  stream word.
- out_index  out  ADDR_WIDTH  LBR address the word came from.
- out_last  out  1  marks word 2*LBR_DEPTH-1.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses, inclusive.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE, all outputs 0, buffer empty, address counter 0, in-flight flag 0.
  - Reset mid-drain discards buffered words with no clear issued.
- Word map:
  - Address 2k = source PC of record k.
  - Address 2k+1 = branch target of record k.
  - Addresses run 0 .. 2*LBR_DEPTH-1.
- LBR timing:
  - lbrReq/RW_address are registered outputs.
  - A read presented in cycle t returns lbr_data in cycle t+1; the engine captures it at the end of t+1.
- Buffering:
  - 2-entry output FIFO holding data+index.
  - A read is issued in a cycle only if (FIFO occupancy + in-flight reads) < 2 after this cycle's pop. This guarantees no returned word is ever dropped under backpressure.
- Stream:
  - out_valid = FIFO non-empty; out_data/out_index/out_last come from the FIFO head.
  - Transfer occurs when out_valid & out_ready.
  - Head fields stay stable while out_valid=1 and out_ready=0.
- States:
  - IDLE: start=1 latches clear_after, sets address=0, goes to READ.
  - READ: issues reads per the credit rule, incrementing the address after each issue. After issuing address 2*LBR_DEPTH-1, goes to WAIT.
  - WAIT: no requests. When the last word (out_last) transfers, goes to CLEAR if the latched clear_after=1, else DONE.
  - CLEAR: drives lbrReq=2'b11, RW_address=0 for exactly one cycle, then DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Throughput: with out_ready held 1, one word is produced per cycle. The first out_valid appears 2 cycles after start is sampled.
- Boundaries:
  - start during busy: ignored, no restart.
  - start and done in the same cycle: start ignored.
  - out_ready=0 throughout: at most 2 reads are issued, then requests stop until the FIFO drains.
  - Address counter never exceeds 2*LBR_DEPTH-1; no wrap.
  - Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.

Test Plan:
- Preload the LBR with records k: src=k, tgt=16'h0100+k; pulse start, clear_after=0, out_ready=1 → 16 words in order 0,16'h0100,1,16'h0101,…,7,16'h0107. out_index 0..15, out_last only on index 15, done pulses once, lbrReq never 2'b11.
- Same, clear_after=1 → after index 15 transfers, exactly one cycle of lbrReq=2'b11, then done. A follow-up drain reads the LBR's cleared values.
- out_ready toggled 1,0,0,1 repeating → same 16-word sequence, no loss or duplication. Head stable while stalled; never more than 2 reads outstanding or buffered.
- out_ready=0 for 20 cycles after start → exactly 2 read requests (addresses 0,1), then lbrReq=2'b00 until out_ready rises.
- start pulsed again at word 5 → ignored, sequence unaffected, single done.
- reset driven low at word 9 → all outputs 0 within the same cycle (asynchronous). After release, a new start produces a clean drain from index 0.

Source files
------------

// File: rtl/lbr_drain_engine.sv
// Drains every LBR branch record (source PC, target) into a valid/ready word
// stream with a 2-entry output FIFO, optionally clearing the LBR afterwards.
//
// state   | meaning
// S_IDLE  | waiting for start; the accepted start also issues the read of address 0
// S_READ  | issuing reads whenever FIFO credit allows
// S_WAIT  | all reads issued; waiting for the last word to transfer
// S_CLEAR | one-cycle LBR clear request on the bus
// S_DONE  | one-cycle completion pulse

module lbr_drain_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LBR_DEPTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear_after,
  output logic [1:0]            lbrReq,
  output logic [ADDR_WIDTH-1:0] RW_address,
  input  logic [DATA_WIDTH-1:0] lbr_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(2 * LBR_DEPTH - 1);
  localparam logic [1:0] REQ_IDLE  = 2'b00;
  localparam logic [1:0] REQ_READ  = 2'b10;
  localparam logic [1:0] REQ_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  clear_q, clear_d;
  logic [1:0]            req_q, req_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic                  pend_q;
  logic [ADDR_WIDTH-1:0] pend_idx_q;

  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [ADDR_WIDTH-1:0] fifo_idx  [2];
  logic                  rd_ptr, wr_ptr;
  logic [1:0]            count_q;

  logic                  push, pop, can_issue, head_last;
  logic [2:0]            committed;

  assign lbrReq     = req_q;
  assign RW_address = raddr_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

  assign out_valid  = (count_q != 2'd0);
  assign pop        = out_valid & out_ready;
  assign push       = pend_q;
  assign head_last  = out_valid && (fifo_idx[rd_ptr] == LAST_ADDR);
  assign out_data   = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_index  = out_valid ? fifo_idx[rd_ptr] : '0;
  assign out_last   = head_last;

  // Every word already buffered or still travelling through the LBR must have
  // a FIFO slot waiting for it, so a stalled consumer can never cause a drop.
  assign committed  = {1'b0, count_q} - {2'b00, pop} + {2'b00, pend_q}
                    + {2'b00, (req_q == REQ_READ)};
  assign can_issue  = (committed < 3'd2);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    clear_d = clear_q;
    req_d   = REQ_IDLE;
    raddr_d = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          clear_d = clear_after;
          req_d   = REQ_READ;
          raddr_d = '0;
          addr_d  = ADDR_WIDTH'(1);
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (can_issue) begin
          req_d   = REQ_READ;
          raddr_d = addr_q;
          if (addr_q == LAST_ADDR) begin
            state_d = S_WAIT;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_WAIT: begin
        if (pop && head_last) begin
          if (clear_q) begin
            req_d   = REQ_CLEAR;
            state_d = S_CLEAR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_CLEAR: state_d = S_DONE;
      S_DONE: begin
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      clear_q    <= 1'b0;
      req_q      <= REQ_IDLE;
      raddr_q    <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      clear_q    <= clear_d;
      req_q      <= req_d;
      raddr_q    <= raddr_d;
      pend_q     <= (req_q == REQ_READ);
      pend_idx_q <= raddr_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_idx[0]  <= '0;
      fifo_idx[1]  <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= lbr_data;
        fifo_idx[wr_ptr]  <= pend_idx_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_lbr_drain_engine.sv
// Self-checking bench for lbr_drain_engine: behavioural LBR memory, stream
// monitor, and a record-level reference of the expected word sequence.

module tb_lbr_drain_engine;

  localparam int DW    = 16;
  localparam int AW    = 16;
  localparam int DEPTH = 8;
  localparam int NW    = 2 * DEPTH;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          clear_after = 1'b0;
  logic          out_ready = 1'b0;
  logic [1:0]    lbrReq;
  logic [AW-1:0] RW_address;
  logic [DW-1:0] lbr_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  lbr_drain_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LBR_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .start(start), .clear_after(clear_after),
    .lbrReq(lbrReq), .RW_address(RW_address), .lbr_data(lbr_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  // Behavioural LBR: registered read port, clear zeroes every record.
  logic [DW-1:0] lbr_mem [NW];
  logic [DW-1:0] src [DEPTH];
  logic [DW-1:0] tgt [DEPTH];
  int lbr_clr_epoch = 0;
  int preload_epoch = 0;

  always @(posedge clock) begin
    if (lbrReq == 2'b10)
      lbr_data <= (lbr_clr_epoch != preload_epoch) ? '0 : lbr_mem[RW_address[3:0]];
    else if (lbrReq == 2'b11)
      lbr_clr_epoch <= lbr_clr_epoch + 1;
  end

  int cyc = 0;
  always @(posedge clock) cyc = cyc + 1;

  // Monitor, sampled mid-cycle.
  logic          log_clr_req = 1'b0;
  int            rd_cnt, xfer_cnt, clr_cnt, done_cnt, bad_addr_cnt;
  int            stall_viol, outst_viol, busy_done_bad;
  int            first_valid_cyc, clr_cyc, done_cyc, last_xfer_cyc;
  logic [AW-1:0] rd_addrs [$];
  logic [DW-1:0] w_data [$];
  logic [AW-1:0] w_idx [$];
  bit            w_last [$];
  logic          prev_valid, prev_ready, prev_last, prev_rst;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_idx;

  always @(negedge clock) begin
    if (log_clr_req) begin
      rd_cnt = 0; xfer_cnt = 0; clr_cnt = 0; done_cnt = 0; bad_addr_cnt = 0;
      stall_viol = 0; outst_viol = 0; busy_done_bad = 0;
      first_valid_cyc = -1; clr_cyc = -1; done_cyc = -1; last_xfer_cyc = -1;
      rd_addrs.delete(); w_data.delete(); w_idx.delete(); w_last.delete();
    end else begin
      if (lbrReq == 2'b10) begin
        rd_cnt++;
        rd_addrs.push_back(RW_address);
        if (rd_cnt - xfer_cnt > 2) outst_viol++;
      end
      if (lbrReq == 2'b11) begin
        clr_cnt++;
        clr_cyc = cyc;
        if (RW_address != '0) bad_addr_cnt++;
      end
      if (lbrReq == 2'b00 && RW_address != '0) bad_addr_cnt++;
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_valid && !prev_ready && reset && prev_rst)
        if (!out_valid || out_data !== prev_data || out_index !== prev_idx || out_last !== prev_last)
          stall_viol++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (!busy) busy_done_bad++;
      end
      if (out_valid && out_ready) begin
        xfer_cnt++;
        w_data.push_back(out_data);
        w_idx.push_back(out_index);
        w_last.push_back(out_last);
        if (out_last) last_xfer_cyc = cyc;
      end
    end
    prev_valid = out_valid; prev_ready = out_ready; prev_last = out_last;
    prev_data = out_data; prev_idx = out_index; prev_rst = reset;
  end

  task automatic clear_log();
    log_clr_req = 1'b1;
    @(negedge clock); #1;
    log_clr_req = 1'b0;
  endtask

  task automatic preload(input bit rnd);
    for (int k = 0; k < DEPTH; k++) begin
      src[k] = rnd ? DW'($urandom) : DW'(k);
      tgt[k] = rnd ? DW'($urandom) : DW'(16'h0100 + k);
      lbr_mem[2*k]   = src[k];
      lbr_mem[2*k+1] = tgt[k];
    end
    preload_epoch = lbr_clr_epoch;
  endtask

  // Number of stream words that differ from the record-level reference.
  task automatic seq_errors(output int bad);
    int n;
    n = w_data.size();
    bad = (n == NW) ? 0 : 1;
    for (int i = 0; i < NW && i < n; i++) begin
      logic [DW-1:0] e;
      e = (i % 2 == 1) ? tgt[i/2] : src[i/2];
      if (w_data[i] !== e || w_idx[i] !== AW'(i) || w_last[i] !== (i == NW - 1)) bad++;
    end
  endtask

  int start_cyc;

  task automatic run_drain(input bit clr, input int mode, input bit do_start,
                           input int restart_at, output bit timed_out);
    bit restarted = 1'b0;
    if (do_start) begin
      @(posedge clock); #1;
      start = 1'b1;
      clear_after = clr;
      start_cyc = cyc;
      out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    timed_out = 1'b1;
    for (int t = 0; t < 400; t++) begin
      @(posedge clock); #1;
      start = 1'b0;
      clear_after = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (t % 4 == 0) || (t % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (restart_at >= 0 && !restarted && xfer_cnt >= restart_at) begin
        start = 1'b1;
        restarted = 1'b1;
      end
      if (done) begin
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (lbrReq !== 2'b00) begin n_err++; $display("FAIL reset_lbrReq: got %b, required 00", lbrReq); end
    n_cmp++; if (RW_address !== '0) begin n_err++; $display("FAIL reset_addr: got %0h, required 0", RW_address); end
    n_cmp++; if ({out_valid, out_last, busy, done} !== 4'b0) begin n_err++;
      $display("FAIL reset_flags: got %b, required 0000", {out_valid, out_last, busy, done}); end
    n_cmp++; if ({out_data, out_index} !== '0) begin n_err++;
      $display("FAIL reset_stream: got %0h/%0h, required 0/0", out_data, out_index); end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if ({busy, out_valid, lbrReq} !== 4'b0) begin n_err++;
      $display("FAIL post_reset_idle: got %b, required 0000", {busy, out_valid, lbrReq}); end
    clear_log();
  endtask

  task automatic test_basic();
    bit to; int bad;
    preload(1'b0);
    clear_log();
    run_drain(1'b0, 0, 1'b1, -1, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL basic_timeout: got timeout, required done"); end
    seq_errors(bad);
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL basic_seq: got %0d bad of %0d words, required 0 bad of %0d", bad, w_data.size(), NW); end
    n_cmp++; if (first_valid_cyc - start_cyc !== 3) begin n_err++;
      $display("FAIL basic_latency: got %0d, required 3 (start cycle + 1 sample + 2)", first_valid_cyc - start_cyc); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d, required 1", done_cnt); end
    n_cmp++; if (clr_cnt !== 0) begin n_err++; $display("FAIL basic_no_clear: got %0d, required 0", clr_cnt); end
    n_cmp++; if (rd_cnt !== NW) begin n_err++; $display("FAIL basic_reads: got %0d, required %0d", rd_cnt, NW); end
    n_cmp++; if (bad_addr_cnt + busy_done_bad !== 0) begin n_err++;
      $display("FAIL basic_addr_busy: got %0d, required 0", bad_addr_cnt + busy_done_bad); end
    repeat (5) @(posedge clock);
    #1;
    n_cmp++; if ({busy, rd_cnt} !== {1'b0, 32'(NW)}) begin n_err++;
      $display("FAIL start_on_done_ignored: got busy=%0d reads=%0d, required busy=0 reads=%0d", busy, rd_cnt, NW); end
  endtask

  task automatic test_clear();
    bit to; int bad;
    preload(1'b1);
    clear_log();
    run_drain(1'b1, 2, 1'b1, -1, to);
    n_cmp++; if (to) begin n_err++; $display("FAIL clear_timeout: got timeout, required done"); end
    seq_errors(bad);
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL clear_seq: got %0d bad, required 0", bad); end
    n_cmp++; if (clr_cnt !== 1) begin n_err++; $display("FAIL clear_count: got %0d, required 1", clr_cnt); end
    n_cmp++; if (clr_cyc !== last_xfer_cyc + 1) begin n_err++;
      $display("FAIL clear_timing: got cycle %0d, required %0d", clr_cyc, last_xfer_cyc + 1); end
    n_cmp++; if (done_cyc !== clr_cyc + 1) begin n_err++;
      $display("FAIL clear_done_timing: got cycle %0d, required %0d", done_cyc, clr_cyc + 1); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL clear_done_count: got %0d, required 1", done_cnt); end
    for (int k = 0; k < DEPTH; k++) begin src[k] = '0; tgt[k] = '0; end
    clear_log();
    run_drain(1'b0, 0, 1'b1, -1, to);
    seq_errors(bad);
    n_cmp++; if (to || bad !== 0) begin n_err++;
      $display("FAIL cleared_readback: got %0d bad (timeout=%0d), required 0", bad, to); end
  endtask

  task automatic test_backpressure();
    bit to; int bad;
    preload(1'b1);
    clear_log();
    run_drain(1'b0, 1, 1'b1, -1, to);
    seq_errors(bad);
    n_cmp++; if (to || bad !== 0) begin n_err++; $display("FAIL bp_seq: got %0d bad (timeout=%0d), required 0", bad, to); end
    n_cmp++; if (stall_viol !== 0) begin n_err++; $display("FAIL bp_head_stable: got %0d changes, required 0", stall_viol); end
    n_cmp++; if (outst_viol !== 0) begin n_err++; $display("FAIL bp_outstanding: got %0d over-issues, required 0", outst_viol); end
    n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL bp_done_count: got %0d, required 1", done_cnt); end
    for (int r = 0; r < 3; r++) begin
      preload(1'b1);
      clear_log();
      run_drain(1'b0, 2, 1'b1, -1, to);
      seq_errors(bad);
      n_cmp++; if (to || bad !== 0 || stall_viol !== 0 || outst_viol !== 0) begin n_err++;
        $display("FAIL random_ready_%0d: got bad=%0d stall=%0d outst=%0d timeout=%0d, required all 0",
                 r, bad, stall_viol, outst_viol, to); end
    end
  endtask

  task automatic test_stall_start();
    bit to; int bad;
    logic [2*AW-1:0] first_two;
    preload(1'b1);
    clear_log();
    @(posedge clock); #1;
    out_ready = 1'b0; start = 1'b1; clear_after = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (19) @(posedge clock);
    #1;
    n_cmp++; if (rd_cnt !== 2) begin n_err++; $display("FAIL stall_reads: got %0d, required 2", rd_cnt); end
    first_two = (rd_addrs.size() >= 2) ? {rd_addrs[0], rd_addrs[1]} : '1;
    n_cmp++; if (first_two !== {AW'(0), AW'(1)}) begin n_err++;
      $display("FAIL stall_addrs: got %0h, required addresses 0 then 1", first_two); end
    n_cmp++; if ({out_valid, out_index, lbrReq} !== {1'b1, AW'(0), 2'b00}) begin n_err++;
      $display("FAIL stall_head: got valid=%0d idx=%0d req=%b, required 1/0/00", out_valid, out_index, lbrReq); end
    run_drain(1'b0, 0, 1'b0, -1, to);
    seq_errors(bad);
    n_cmp++; if (to || bad !== 0 || rd_cnt !== NW) begin n_err++;
      $display("FAIL stall_resume: got bad=%0d reads=%0d timeout=%0d, required 0/%0d/0", bad, rd_cnt, to, NW); end
  endtask

  task automatic test_restart_ignored();
    bit to; int bad;
    preload(1'b1);
    clear_log();
    run_drain(1'b0, 2, 1'b1, 5, to);
    seq_errors(bad);
    n_cmp++; if (to || bad !== 0) begin n_err++; $display("FAIL restart_seq: got %0d bad (timeout=%0d), required 0", bad, to); end
    n_cmp++; if (done_cnt !== 1 || rd_cnt !== NW) begin n_err++;
      $display("FAIL restart_single: got done=%0d reads=%0d, required 1/%0d", done_cnt, rd_cnt, NW); end
  endtask

  task automatic test_reset_mid();
    bit to; int bad;
    preload(1'b1);
    clear_log();
    @(posedge clock); #1;
    start = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < 100 && xfer_cnt < 9; t++) begin
      @(posedge clock); #1;
      start = 1'b0;
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if ({lbrReq, RW_address, out_valid, out_data, out_index, out_last, busy, done} !== '0) begin n_err++;
      $display("FAIL async_reset_outputs: got req=%b addr=%0h v=%0d d=%0h i=%0h l=%0d busy=%0d done=%0d, required all 0",
               lbrReq, RW_address, out_valid, out_data, out_index, out_last, busy, done); end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    n_cmp++; if (clr_cnt !== 0) begin n_err++; $display("FAIL reset_no_clear: got %0d, required 0", clr_cnt); end
    clear_log();
    run_drain(1'b0, 0, 1'b1, -1, to);
    seq_errors(bad);
    n_cmp++; if (to || bad !== 0 || clr_cnt !== 0) begin n_err++;
      $display("FAIL post_reset_drain: got bad=%0d clears=%0d timeout=%0d, required 0/0/0", bad, clr_cnt, to); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clear();
    test_backpressure();
    test_stall_start();
    test_restart_ignored();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
